// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, control bundle layout and field helpers for the decode stage
package decode_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [6:0] FN7_BASE   = 7'b0000000;
    localparam logic [6:0] FN7_ALT    = 7'b0100000;
    localparam logic [6:0] FN7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // Control bundle bit positions, LSB first
    localparam int ALU_OP    = 0;   // 3 bits
    localparam int ALU_IMM   = 3;
    localparam int ALU_SUB   = 4;
    localparam int ALU_SRA   = 5;
    localparam int ALU_WORD  = 6;
    localparam int IS_MUL    = 7;
    localparam int RD_W      = 8;
    localparam int LD_UPPER  = 9;
    localparam int ADD_PC    = 10;
    localparam int JMP_REG   = 11;
    localparam int IS_BRANCH = 12;
    localparam int IS_JMP    = 13;
    localparam int IS_LOAD   = 14;
    localparam int IS_STORE  = 15;
    localparam int IS_FENCE  = 16;
    localparam int IS_FENCEI = 17;
    localparam int IS_CSR    = 18;
    localparam int IS_MRET   = 19;
    localparam int EXC_ECALL = 20;
    localparam int EXC_BREAK = 21;
    localparam int CSR_ZIMM  = 22;
    localparam int CSR_W     = 23;
    localparam int CSR_SET   = 24;
    localparam int CSR_CLR   = 25;
    localparam int ILLEGAL   = 26;
    localparam int CTRL_W    = 27;

    function automatic logic [6:0] f_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [2:0] f_fn3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [6:0] f_fn7(input logic [31:0] inst);
        return inst[31:25];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational instruction word to control bundle decoder
// Ports: inst (32-bit instruction) -> ctrl (CTRL_W packed bundle, layout in decode_pkg)
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MEXT = 0
) (
    input  logic [31:0]       inst,
    output logic [CTRL_W-1:0] ctrl
);

    localparam bit RV32  = (XLEN == 32);
    localparam bit HAS_M = (MEXT != 0);

    logic [6:0] opc;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic [4:0] rd;

    assign opc = f_opcode(inst);
    assign fn3 = f_fn3(inst);
    assign fn7 = f_fn7(inst);
    assign rd  = f_rd(inst);

    logic is_lui, is_auipc, is_opimm, is_opimm32, is_op, is_op32;
    logic is_jal, is_jalr, is_br, is_ld, is_st, is_mm, is_sys;

    assign is_lui     = (opc == OPC_LUI);
    assign is_auipc   = (opc == OPC_AUIPC);
    assign is_opimm   = (opc == OPC_OPIMM);
    assign is_opimm32 = (opc == OPC_OPIMM32);
    assign is_op      = (opc == OPC_OP);
    assign is_op32    = (opc == OPC_OP32);
    assign is_jal     = (opc == OPC_JAL);
    assign is_jalr    = (opc == OPC_JALR);
    assign is_br      = (opc == OPC_BRANCH);
    assign is_ld      = (opc == OPC_LOAD);
    assign is_st      = (opc == OPC_STORE);
    assign is_mm      = (opc == OPC_MISCMEM);
    assign is_sys     = (opc == OPC_SYSTEM);

    logic known, r_type, fn7_ok, sh_imm, sys0, sys_csr;
    logic ecall, ebreak, mret, alt_imm, illegal;

    assign known   = is_lui | is_auipc | is_opimm | is_opimm32 | is_op | is_op32 |
                     is_jal | is_jalr | is_br | is_ld | is_st | is_mm | is_sys;
    assign r_type  = is_op | is_op32;
    assign fn7_ok  = (fn7 == FN7_BASE) | (fn7 == FN7_ALT) | (HAS_M & (fn7 == FN7_MULDIV));
    assign sh_imm  = is_opimm & ((fn3 == 3'b001) | (fn3 == 3'b101));
    assign sys0    = is_sys & (fn3 == 3'b000);
    assign sys_csr = is_sys & (fn3 != 3'b000) & (fn3 != 3'b100);
    assign ecall   = (inst == INST_ECALL);
    assign ebreak  = (inst == INST_EBREAK);
    assign mret    = (inst == INST_MRET);
    // RV64 shift-immediates carry shamt[5] in inst[25], so only fn7[6:1] selects SRA
    assign alt_imm = RV32 ? (fn7 == FN7_ALT) : (fn7[6:1] == FN7_ALT[6:1]);

    assign illegal = ~known | (inst[1:0] != 2'b11)
                   | (r_type & ~fn7_ok)
                   | (r_type & (fn7 == FN7_ALT) & (fn3 != 3'b000) & (fn3 != 3'b101))
                   | (RV32 & (is_op32 | is_opimm32))
                   | (RV32 & sh_imm & inst[25])
                   | (is_ld & ((fn3 == 3'b111) | (RV32 & ((fn3 == 3'b011) | (fn3 == 3'b110)))))
                   | (is_st & (fn3[2] | (RV32 & (fn3 == 3'b011))))
                   | (is_br & (fn3[2:1] == 2'b01))
                   | (is_jalr & (fn3 != 3'b000))
                   | (is_sys & (fn3 == 3'b100))
                   | (sys0 & ~(ecall | ebreak | mret));

    logic writes;
    assign writes = is_lui | is_auipc | is_opimm | is_opimm32 | r_type |
                    is_jal | is_jalr | is_ld | sys_csr;

    always_comb begin
        ctrl = '0;
        if (illegal) begin
            ctrl[ILLEGAL] = 1'b1;
        end else begin
            ctrl[ALU_OP +: 3] = (is_jal | is_jalr | is_ld | is_st) ? 3'b000 : fn3;
            ctrl[ALU_IMM]   = is_opimm | is_opimm32 | is_ld | is_st | is_jalr;
            ctrl[ALU_SUB]   = r_type & (fn3 == 3'b000) & (fn7 == FN7_ALT);
            ctrl[ALU_SRA]   = (fn3 == 3'b101) &
                              (((r_type | is_opimm32) & (fn7 == FN7_ALT)) | (is_opimm & alt_imm));
            ctrl[ALU_WORD]  = is_op32 | is_opimm32;
            ctrl[IS_MUL]    = r_type & (fn7 == FN7_MULDIV);
            ctrl[RD_W]      = writes & (rd != 5'd0);
            ctrl[LD_UPPER]  = is_lui;
            ctrl[ADD_PC]    = is_auipc;
            ctrl[JMP_REG]   = is_jalr;
            ctrl[IS_BRANCH] = is_br;
            ctrl[IS_JMP]    = is_jal | is_jalr;
            ctrl[IS_LOAD]   = is_ld;
            ctrl[IS_STORE]  = is_st;
            ctrl[IS_FENCE]  = is_mm & (fn3 == 3'b000);
            ctrl[IS_FENCEI] = is_mm & (fn3 == 3'b001);
            ctrl[IS_CSR]    = sys_csr;
            ctrl[IS_MRET]   = mret;
            ctrl[EXC_ECALL] = ecall;
            ctrl[EXC_BREAK] = ebreak;
            ctrl[CSR_ZIMM]  = sys_csr & fn3[2];
            ctrl[CSR_W]     = sys_csr & (fn3[1:0] == 2'b01);
            ctrl[CSR_SET]   = sys_csr & (fn3[1:0] == 2'b10);
            ctrl[CSR_CLR]   = sys_csr & (fn3[1:0] == 2'b11);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered valid/ready decode stage with 2-entry skid buffer
// Ports: clk, rst_n (async active-low), flush; in_valid/in_ready/in_inst/in_pc from fetch;
//        out_valid/out_ready/out_inst/out_pc/out_ctrl to register-read
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MEXT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic [CTRL_W-1:0] dec_ctrl;

    decode_comb #(.XLEN(XLEN), .MEXT(MEXT)) u_decode_comb (
        .inst (in_inst),
        .ctrl (dec_ctrl)
    );

    logic              skid_valid;
    logic [31:0]       skid_inst;
    logic [XLEN-1:0]   skid_pc;
    logic [CTRL_W-1:0] skid_ctrl;

    logic push;
    assign push = in_valid & in_ready;

    // The main register doubles as the output register; skid is only ever
    // occupied while main is, so main freeing up always drains skid first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_inst   <= '0;
            out_pc     <= '0;
            out_ctrl   <= '0;
            skid_valid <= 1'b0;
            skid_inst  <= '0;
            skid_pc    <= '0;
            skid_ctrl  <= '0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_inst   <= skid_inst;
                out_pc     <= skid_pc;
                out_ctrl   <= skid_ctrl;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (push) begin
                out_valid <= 1'b1;
                out_inst  <= in_inst;
                out_pc    <= in_pc;
                out_ctrl  <= dec_ctrl;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_inst  <= in_inst;
            skid_pc    <= in_pc;
            skid_ctrl  <= dec_ctrl;
            in_ready   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (RV32 no-M and RV64 with-M instances)
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic rdy32, rdy64, v32, v64;
    logic [31:0] oi32, oi64, op32;
    logic [63:0] op64;
    logic [CTRL_W-1:0] c32, c64;

    decode_stage #(.XLEN(32), .MEXT(0)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32), .in_inst(in_inst), .in_pc(in_pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_inst(oi32), .out_pc(op32), .out_ctrl(c32)
    );

    decode_stage #(.XLEN(64), .MEXT(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_inst(oi64), .out_pc(op64), .out_ctrl(c64)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules
    function automatic logic [CTRL_W-1:0] ref_ctrl(input logic [31:0] i, input bit x64, input bit m);
        logic [CTRL_W-1:0] c;
        logic [2:0] f3, aop;
        logic [6:0] f7;
        bit bad, wr;
        c = '0; f3 = i[14:12]; f7 = i[31:25]; aop = f3; wr = 0;
        bad = (i[1:0] != 2'b11);
        case (i[6:0])
            7'h37: begin wr = 1; c[LD_UPPER] = 1; end
            7'h17: begin wr = 1; c[ADD_PC] = 1; end
            7'h13: begin
                wr = 1; c[ALU_IMM] = 1;
                if ((f3 == 1 || f3 == 5) && !x64 && i[25]) bad = 1;
                if (f3 == 5 && (x64 ? (i[31:26] == 6'b010000) : (f7 == 7'h20))) c[ALU_SRA] = 1;
            end
            7'h1B: begin
                if (!x64) bad = 1;
                wr = 1; c[ALU_IMM] = 1; c[ALU_WORD] = 1;
                if (f3 == 5 && f7 == 7'h20) c[ALU_SRA] = 1;
            end
            7'h33, 7'h3B: begin
                if (i[6:0] == 7'h3B) begin
                    if (!x64) bad = 1;
                    c[ALU_WORD] = 1;
                end
                wr = 1;
                if (f7 == 7'h20) begin
                    if (f3 == 0) c[ALU_SUB] = 1;
                    else if (f3 == 5) c[ALU_SRA] = 1;
                    else bad = 1;
                end else if (f7 == 7'h01) begin
                    if (m) c[IS_MUL] = 1; else bad = 1;
                end else if (f7 != 7'h00) bad = 1;
            end
            7'h6F: begin wr = 1; c[IS_JMP] = 1; aop = 0; end
            7'h67: begin
                wr = 1; c[IS_JMP] = 1; c[JMP_REG] = 1; c[ALU_IMM] = 1; aop = 0;
                if (f3 != 0) bad = 1;
            end
            7'h63: begin c[IS_BRANCH] = 1; if (f3 == 2 || f3 == 3) bad = 1; end
            7'h03: begin
                wr = 1; c[IS_LOAD] = 1; c[ALU_IMM] = 1; aop = 0;
                if (f3 == 7 || (!x64 && (f3 == 3 || f3 == 6))) bad = 1;
            end
            7'h23: begin
                c[IS_STORE] = 1; c[ALU_IMM] = 1; aop = 0;
                if (f3 >= 4 || (!x64 && f3 == 3)) bad = 1;
            end
            7'h0F: begin
                if (f3 == 0) c[IS_FENCE] = 1;
                if (f3 == 1) c[IS_FENCEI] = 1;
            end
            7'h73: begin
                if (f3 == 4) bad = 1;
                else if (f3 == 0) begin
                    if (i == 32'h00000073) c[EXC_ECALL] = 1;
                    else if (i == 32'h00100073) c[EXC_BREAK] = 1;
                    else if (i == 32'h30200073) c[IS_MRET] = 1;
                    else bad = 1;
                end else begin
                    wr = 1; c[IS_CSR] = 1; c[CSR_ZIMM] = f3[2];
                    c[CSR_W] = (f3[1:0] == 1); c[CSR_SET] = (f3[1:0] == 2); c[CSR_CLR] = (f3[1:0] == 3);
                end
            end
            default: bad = 1;
        endcase
        if (wr && i[11:7] != 0) c[RD_W] = 1;
        c[ALU_OP +: 3] = aop;
        if (bad) begin
            c = '0;
            c[ILLEGAL] = 1;
        end
        return c;
    endfunction

    // Literal field expectations for the named example instructions
    task automatic check_directed(input bit x64, input logic [31:0] inst, input logic [CTRL_W-1:0] c);
        logic [63:0] only_ill;
        only_ill = 64'd1 << ILLEGAL;
        case (inst)
            32'h003100B3: begin
                chk("add rd_w", c[RD_W], 1); chk("add alu_sub", c[ALU_SUB], 0);
                chk("add illegal", c[ILLEGAL], 0); chk("add alu_op", c[ALU_OP +: 3], 0);
            end
            32'h403100B3: chk("sub alu_sub", c[ALU_SUB], 1);
            32'h40335293: begin chk("srai alu_sra", c[ALU_SRA], 1); chk("srai alu_imm", c[ALU_IMM], 1); end
            32'h00712623: begin chk("sw alu_imm", c[ALU_IMM], 1); chk("sw rd_w", c[RD_W], 0); end
            32'h003100BB: begin
                if (!x64) chk("addw32 ctrl", c, only_ill);
                else begin
                    chk("addw64 alu_word", c[ALU_WORD], 1); chk("addw64 rd_w", c[RD_W], 1);
                    chk("addw64 illegal", c[ILLEGAL], 0);
                end
            end
            32'h023100B3: begin
                if (!x64) chk("mul noM ctrl", c, only_ill);
                else begin chk("mul M is_mul", c[IS_MUL], 1); chk("mul M rd_w", c[RD_W], 1); end
            end
            32'h00000013: chk("nop rd_w", c[RD_W], 0);
            32'h00000073: chk("ecall exc_ecall", c[EXC_ECALL], 1);
            32'h30200073: chk("mret is_mret", c[IS_MRET], 1);
            32'h3002D0F3: begin chk("csrrwi csr_w", c[CSR_W], 1); chk("csrrwi csr_zimm", c[CSR_ZIMM], 1); end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        chk("out_valid32", v32, q.size() > 0);
        chk("out_valid64", v64, q.size() > 0);
        chk("in_ready32", rdy32, q.size() < 2);
        chk("in_ready64", rdy64, q.size() < 2);
        if (q.size() > 0) begin
            chk("out_inst32", oi32, q[0].inst);
            chk("out_inst64", oi64, q[0].inst);
            chk("out_pc32", op32, q[0].pc[31:0]);
            chk("out_pc64", op64, q[0].pc);
            chk("out_ctrl32", c32, ref_ctrl(q[0].inst, 0, 0));
            chk("out_ctrl64", c64, ref_ctrl(q[0].inst, 1, 1));
            check_directed(0, q[0].inst, c32);
            check_directed(1, q[0].inst, c64);
        end
    endtask

    task automatic step(output bit acc);
        bit pop, push, fl;
        item_t it;
        @(negedge clk);
        check_outputs();
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        fl   = flush;
        it.inst = in_inst;
        it.pc   = in_pc;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(it);
        end
        acc = push && !fl;
    endtask

    task automatic tick();
        bit dummy;
        step(dummy);
    endtask

    task automatic feed(input logic [31:0] inst);
        in_valid = 1; in_inst = inst; in_pc = {$urandom, $urandom}; out_ready = 1;
        tick();
        in_valid = 0;
        tick();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        logic [6:0] opcs [13];
        int k, s;
        opcs = '{7'h37, 7'h17, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73};
        r = $urandom;
        k = $urandom_range(0, 15);
        if (k < 13) begin
            r[6:0] = opcs[k];
            s = $urandom_range(0, 3);
            if (s == 0) r[31:25] = 7'h00;
            else if (s == 1) r[31:25] = 7'h20;
            else if (s == 2) r[31:25] = 7'h01;
        end else if (k == 13) begin
            s = $urandom_range(0, 2);
            r = (s == 0) ? 32'h00000073 : (s == 1) ? 32'h00100073 : 32'h30200073;
        end
        return r;
    endfunction

    logic [31:0] stream [6];
    int idx;
    bit acc;

    initial begin
        stream = '{32'h403100B3, 32'h40335293, 32'h00812383, 32'h00712623, 32'h00208863, 32'h008000EF};
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1; in_inst = 0; in_pc = 0;

        #12;
        chk("rst out_valid32", v32, 0);
        chk("rst out_valid64", v64, 0);
        chk("rst in_ready64", rdy64, 1);
        chk("rst out_ctrl64", c64, 0);
        chk("rst out_inst32", oi32, 0);
        chk("rst out_pc64", op64, 0);
        @(posedge clk); #1;
        rst_n = 1;

        feed(32'h003100B3);

        // Back-to-back stream with a two-cycle downstream stall
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            in_valid = 1; in_inst = stream[idx]; in_pc = 64'h1000 + 64'(idx) * 4;
            out_ready = !(cyc == 2 || cyc == 3);
            step(acc);
            if (acc) idx++;
            if (cyc == 2) chk("stall in_ready", rdy64, 0);
        end
        chk("stream complete", idx, 6);
        in_valid = 0; out_ready = 1;
        repeat (3) tick();

        feed(32'h003100BB);
        feed(32'h023100B3);
        feed(32'h00000013);
        feed(32'h00000073);
        feed(32'h00100073);
        feed(32'h30200073);
        feed(32'h3002D0F3);

        // Fill both entries, then flush with a simultaneous push and pop
        out_ready = 0; in_valid = 1;
        in_inst = 32'h00100093; in_pc = 64'h2000; tick();
        in_inst = 32'h00200113; in_pc = 64'h2004; tick();
        flush = 1; out_ready = 1; in_inst = 32'h00500193; in_pc = 64'h2008;
        tick();
        flush = 0; in_valid = 0;
        chk("flush out_valid", v64, 0);
        chk("flush in_ready", rdy64, 1);
        repeat (2) tick();

        // Asynchronous reset in the middle of traffic
        out_ready = 0; in_valid = 1;
        in_inst = 32'h00300213; in_pc = 64'h3000; tick();
        in_inst = 32'h00400293; in_pc = 64'h3004; tick();
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("arst out_valid32", v32, 0);
        chk("arst out_valid64", v64, 0);
        chk("arst in_ready32", rdy32, 1);
        chk("arst out_ctrl64", c64, 0);
        q.delete();
        #1;
        rst_n = 1;
        out_ready = 1;
        tick();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_inst   = gen_inst();
            in_pc     = {$urandom, $urandom};
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
